// File: rtl/dsp_mac_seq.sv
// Sequencer that drives a DSP48A1-style slice (A1/B1/M/P/OPMODE/CARRYOUT registered)
// as an unsigned multiply-accumulator and returns the sum of `len` products.
module dsp_mac_seq #(
  parameter int          LEN_W      = 16,
  parameter logic [7:0]  ACC_OPMODE = 8'b0000_1001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_data,
  output logic             out_ovf,
  output logic             busy,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_cecarryin,
  output logic             dsp_ceopmode,
  output logic             dsp_rstm,
  output logic             dsp_rstp,
  output logic             dsp_rstcarryin,
  output logic             dsp_rstopmode,
  input  logic [47:0]      dsp_p,
  input  logic             dsp_carryout,
  output logic [2:0]       dbg_state_o
);

  // Handshakes: a transfer happens in any cycle where valid && ready are both high
  // at the rising edge; valid may not depend on ready, ready may depend on valid.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       tok_q;
  logic [47:0]      data_q, data_d;
  logic             ovf_q, ovf_d;
  logic [17:0]      a_q, b_q;
  logic             accept;
  logic             rst_clear;
  logic             drive_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      tok_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      // tok_q[0]=M load, tok_q[1]=P load, tok_q[2]=P/CARRYOUT of that beat visible
      tok_q   <= {tok_q[1:0], accept};
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      a_q     <= dsp_a;
      b_q     <= dsp_b;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    rst_clear = 1'b0;
    drive_op  = 1'b0;
    if (tok_q[2]) ovf_d = ovf_q | dsp_carryout;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = len;
          if (len == '0) begin
            data_d  = '0;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        rst_clear = 1'b1;
        drive_op  = 1'b1;
        count_d   = '0;
        ovf_d     = 1'b0;
        state_d   = FEED;
      end
      FEED: begin
        drive_op = 1'b1;
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          count_d = count_q + ONE;
          if (count_q + ONE == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        drive_op = 1'b1;
        if (tok_q == 3'b100) begin
          data_d  = dsp_p;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dsp_a          = accept ? in_a : a_q;
  assign dsp_b          = accept ? in_b : b_q;
  assign dsp_cea        = accept;
  assign dsp_ceb        = accept;
  assign dsp_cem        = tok_q[0];
  assign dsp_cep        = tok_q[1];
  assign dsp_cecarryin  = tok_q[1];
  assign dsp_opmode     = drive_op ? ACC_OPMODE : 8'h00;
  assign dsp_ceopmode   = drive_op;
  // Slice resets follow the sequencer reset combinationally so both clear together.
  assign dsp_rstm       = !rst_n || rst_clear;
  assign dsp_rstp       = !rst_n || rst_clear;
  assign dsp_rstcarryin = !rst_n || rst_clear;
  assign dsp_rstopmode  = !rst_n;

  assign out_valid   = (state_q == DONE);
  assign out_data    = data_q;
  assign out_ovf     = ovf_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/dsp_mac_seq.md
Name: dsp_mac_seq

Overview:
- Initiator/reader for the DSP48A1-style slice: accepts a stream of (a,b) operand pairs and drives the slice's A/B, OPMODE, clock-enable and reset pins so the slice computes an unsigned multiply-accumulate.
- Reads back the slice's P and CARRYOUT and presents the sum of `len` products on a valid/ready result port.
- Target slice configuration: A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYOUTREG=1, B_INPUT="DIRECT", RSTTYPE="SYNC".

Parameters:
- LEN_W, 16, width of the beat-count input `len`.
- ACC_OPMODE, 8'b0000_1001, OPMODE driven while busy: Z=P, X=M, pre-adder bypass, add, carry-in 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- len  in  LEN_W  number of beats, sampled with start
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid&&in_ready
- in_a  in  18  multiplicand
- in_b  in  18  multiplier
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_data  out  48  accumulated sum mod 2^48
- out_ovf  out  1  sticky: any accumulation carry-out during the operation
- busy  out  1  high in every state except IDLE
- dsp_a, dsp_b  out  18  to slice A, B
- dsp_opmode  out  8  to slice OPMODE
- dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_cecarryin, dsp_ceopmode  out  1  to slice CEs
- dsp_rstm, dsp_rstp, dsp_rstcarryin, dsp_rstopmode  out  1  to slice resets (active-high)
- dsp_p  in  48  from slice P
- dsp_carryout  in  1  from slice CARRYOUT

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE. Count, tokens, out_data, out_ovf, out_valid, in_ready, busy and all CEs are cleared to 0.
  - dsp_a/dsp_b are cleared to 0 and dsp_opmode to 8'h00.
  - All four dsp_rst* outputs are high combinationally whenever rst_n=0, so the slice clears with the sequencer. Reset mid-operation abandons the operation; no result is produced.
- IDLE:
  - start=1, len≠0: go to CLEAR.
  - start=1, len=0: go to DONE with out_data=0 and out_ovf=0; no slice activity.
- CLEAR (1 cycle):
  - dsp_rstm=dsp_rstp=dsp_rstcarryin=1.
  - dsp_ceopmode=1 with dsp_opmode=ACC_OPMODE, which loads the OPMODE register.
  - Clear the beat count and the ovf flag, then go to FEED.
- FEED:
  - in_ready=1 until `len` beats have been accepted. dsp_opmode=ACC_OPMODE and dsp_ceopmode=1 throughout FEED and DRAIN.
  - On accept in cycle t: dsp_a=in_a, dsp_b=in_b, dsp_cea=dsp_ceb=1 in t; count+1.
  - On a non-accept cycle, dsp_cea=dsp_ceb=0 and dsp_a/dsp_b hold.
  - A 3-bit token shift register tok[1..3] shifts the accept bit every cycle:
    - dsp_cem=tok1 (cycle t+1).
    - dsp_cep=dsp_cecarryin=tok2 (cycle t+2).
    - At tok3 (cycle t+3), out_ovf |= dsp_carryout.
  - Bubbles therefore never re-add a stale M.
  - After the cycle that accepts beat `len`, go to DRAIN; in_ready=0 from then on.
- DRAIN:
  - Wait until tok3=1 and tok1=tok2=0.
  - In that cycle, capture out_data<=dsp_p and out_ovf<=out_ovf|dsp_carryout, then go to DONE.
  - Latency: last beat accepted in cycle t gives out_valid high from cycle t+4.
- DONE:
  - out_valid=1, and out_data/out_ovf are held stable while out_valid=1 && out_ready=0.
  - On out_valid&&out_ready, go to IDLE; out_valid drops the next cycle.
  - start is ignored in every state except IDLE. A start asserted in the same cycle as the DONE handshake is ignored.
- Arithmetic:
  - Products are unsigned 18x18→36, zero-extended to 48 bits.
  - out_data equals the sum mod 2^48. Any per-step carry sets out_ovf.

Test Plan:
- len=3; beats (2,3),(4,5),(6,7) back-to-back, out_ready=1 → out_data=68, out_ovf=0; out_valid exactly 4 cycles after the last accept; dsp_cem/dsp_cep each pulse 3 times.
- Same operands with in_valid low for 2 cycles between every beat → out_data=68; dsp_cep pulses exactly 3 times, never during bubbles.
- len=4097; all beats (0x3FFFF,0x3FFFF) → out_ovf=1, out_data=48'd66571472897.
- len=0 with start → out_valid the cycle after DONE entry, out_data=0; dsp_cea never asserted.
- Hold out_ready=0 for 5 cycles in DONE while pulsing start → out_data/out_valid stable, no new op; then out_ready=1 → IDLE. A following start with len=1, beat (5,5) gives out_data=25; P from the previous op is cleared by CLEAR.
- rst_n=0 for 1 cycle mid-FEED of a len=3 op, then a new len=2 op with beats (1,2),(3,4) → no out_valid for the aborted op; the new op gives out_data=14.
